// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Shares one asynchronous SRAM between two requesters.
//               Port 0 is the LC-3 datapath (fetch, LDR, STR). Port 1 is the
//               loader/debug port. Grants are round-robin. Each access runs
//               IDLE -> SETUP -> ACCESS (ACCESS_CYCLES) -> DONE and returns a
//               one-cycle ack to the requester that was granted. All outputs
//               are registered.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   Clk, Reset            : clock, synchronous active-high reset
//   req0/we0/addr0/wdata0 : port 0 request, direction, address, write data
//   ack0                  : port 0 one-cycle completion pulse
//   req1/we1/addr1/wdata1 : port 1 request, direction, address, write data
//   ack1                  : port 1 one-cycle completion pulse
//   rdata                 : read data, valid in the ack cycle, held until the
//                           next read completes
//   busy                  : high in every state except IDLE
//   Mem_ADDR/Mem_Dout     : SRAM address and write data
//   Mem_Din               : SRAM read data
//   Mem_Dout_en           : tristate enable for Mem_Dout
//   Mem_CE/OE/WE/UB/LB    : SRAM strobes, active-low
// ============================================================================
module sram_arbiter #(
  parameter int ADDR_W        = 20,
  parameter int DATA_W        = 16,
  parameter int ACCESS_CYCLES = 2    // legal range 1..15
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] Mem_ADDR,
  output logic [DATA_W-1:0] Mem_Dout,
  input  logic [DATA_W-1:0] Mem_Din,
  output logic              Mem_Dout_en,
  output logic              Mem_CE,
  output logic              Mem_OE,
  output logic              Mem_WE,
  output logic              Mem_UB,
  output logic              Mem_LB
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              sel, sel_nxt;            // granted port
  logic              we_lat, we_lat_nxt;      // latched direction
  logic              last_grant, last_grant_nxt;

  logic              ack0_nxt, ack1_nxt, busy_nxt;
  logic [DATA_W-1:0] rdata_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] dout_nxt;
  logic              dout_en_nxt, ce_nxt, oe_nxt, we_nxt;

  logic              grant0, grant1;

  // Port 0 wins unless port 1 is also requesting and port 0 went last.
  assign grant0 = req0 & (~req1 | last_grant);
  assign grant1 = req1 & ~grant0;

  // Outputs are registered, so every *_nxt value below describes the cycle
  // after the edge, i.e. the strobes belonging to state_nxt. Mem_ADDR and
  // Mem_Dout are loaded at grant and held, which makes them the latched copy
  // of the request address and write data.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    sel_nxt        = sel;
    we_lat_nxt     = we_lat;
    last_grant_nxt = last_grant;
    ack0_nxt       = 1'b0;
    ack1_nxt       = 1'b0;
    busy_nxt       = 1'b1;
    rdata_nxt      = rdata;
    addr_nxt       = Mem_ADDR;
    dout_nxt       = Mem_Dout;
    dout_en_nxt    = 1'b0;
    ce_nxt         = 1'b1;
    oe_nxt         = 1'b1;
    we_nxt         = 1'b1;

    unique case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (grant0 || grant1) begin
          state_nxt      = SETUP;
          busy_nxt       = 1'b1;
          sel_nxt        = grant1;
          last_grant_nxt = grant1;
          we_lat_nxt     = grant1 ? we1 : we0;
          addr_nxt       = grant1 ? addr1 : addr0;
          ce_nxt         = 1'b0;
          if (grant1 ? we1 : we0) begin
            dout_nxt    = grant1 ? wdata1 : wdata0;
            dout_en_nxt = 1'b1;
          end
        end
      end

      SETUP: begin
        state_nxt = ACCESS;
        cnt_nxt   = CNT_LOAD;
        ce_nxt    = 1'b0;
        if (we_lat) begin
          we_nxt      = 1'b0;
          dout_en_nxt = 1'b1;
        end else begin
          oe_nxt = 1'b0;
        end
      end

      ACCESS: begin
        ce_nxt = 1'b0;
        if (cnt == 4'd0) begin
          state_nxt   = DONE;
          // Keep driving the bus through DONE for write data hold time.
          dout_en_nxt = we_lat;
          if (!we_lat) begin
            rdata_nxt = Mem_Din;
          end
          ack0_nxt = ~sel;
          ack1_nxt = sel;
        end else begin
          cnt_nxt = cnt - 4'd1;
          if (we_lat) begin
            we_nxt      = 1'b0;
            dout_en_nxt = 1'b1;
          end else begin
            oe_nxt = 1'b0;
          end
        end
      end

      DONE: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end

      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      sel         <= 1'b0;
      we_lat      <= 1'b0;
      last_grant  <= 1'b1;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      busy        <= 1'b0;
      rdata       <= '0;
      Mem_ADDR    <= '0;
      Mem_Dout    <= '0;
      Mem_Dout_en <= 1'b0;
      Mem_CE      <= 1'b1;
      Mem_OE      <= 1'b1;
      Mem_WE      <= 1'b1;
      Mem_UB      <= 1'b1;
      Mem_LB      <= 1'b1;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      sel         <= sel_nxt;
      we_lat      <= we_lat_nxt;
      last_grant  <= last_grant_nxt;
      ack0        <= ack0_nxt;
      ack1        <= ack1_nxt;
      busy        <= busy_nxt;
      rdata       <= rdata_nxt;
      Mem_ADDR    <= addr_nxt;
      Mem_Dout    <= dout_nxt;
      Mem_Dout_en <= dout_en_nxt;
      Mem_CE      <= ce_nxt;
      Mem_OE      <= oe_nxt;
      Mem_WE      <= we_nxt;
      // Word accesses only: byte enables follow chip enable.
      Mem_UB      <= ce_nxt;
      Mem_LB      <= ce_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_arbiter
// Description : Directed self-checking bench for sram_arbiter. Instance A uses
//               ACCESS_CYCLES=2 with a writable SRAM model; instance B uses
//               ACCESS_CYCLES=1 with a read-only pattern SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- instance A (ACCESS_CYCLES = 2) ----------------
  logic        req0, we0, req1, we1;
  logic [19:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1, busy;
  logic [15:0] rdata;
  logic [19:0] maddr;
  logic [15:0] mdout, mdin;
  logic        mdout_en, mce, moe, mwe, mub, mlb;

  sram_arbiter #(.ADDR_W(20), .DATA_W(16), .ACCESS_CYCLES(2)) dut_a (
    .Clk(Clk), .Reset(Reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .busy(busy),
    .Mem_ADDR(maddr), .Mem_Dout(mdout), .Mem_Din(mdin), .Mem_Dout_en(mdout_en),
    .Mem_CE(mce), .Mem_OE(moe), .Mem_WE(mwe), .Mem_UB(mub), .Mem_LB(mlb)
  );

  logic [15:0] mem_a [0:1048575];
  logic        pl_en = 1'b0;
  logic [19:0] pl_addr;
  logic [15:0] pl_data;

  always @(posedge Clk) begin
    if (pl_en) mem_a[pl_addr] <= pl_data;
    else if (!mce && !mwe) mem_a[maddr] <= mdout;
  end
  assign mdin = !moe ? mem_a[maddr] : 16'h0000;

  // ---------------- instance B (ACCESS_CYCLES = 1) ----------------
  logic        req0b, we0b, req1b, we1b;
  logic [19:0] addr0b, addr1b;
  logic [15:0] wdata0b, wdata1b;
  logic        ack0b, ack1b, busyb;
  logic [15:0] rdatab;
  logic [19:0] maddrb;
  logic [15:0] mdoutb, mdinb;
  logic        mdout_enb, mceb, moeb, mweb, mubb, mlbb;

  sram_arbiter #(.ADDR_W(20), .DATA_W(16), .ACCESS_CYCLES(1)) dut_b (
    .Clk(Clk), .Reset(Reset),
    .req0(req0b), .we0(we0b), .addr0(addr0b), .wdata0(wdata0b), .ack0(ack0b),
    .req1(req1b), .we1(we1b), .addr1(addr1b), .wdata1(wdata1b), .ack1(ack1b),
    .rdata(rdatab), .busy(busyb),
    .Mem_ADDR(maddrb), .Mem_Dout(mdoutb), .Mem_Din(mdinb), .Mem_Dout_en(mdout_enb),
    .Mem_CE(mceb), .Mem_OE(moeb), .Mem_WE(mweb), .Mem_UB(mubb), .Mem_LB(mlbb)
  );

  // Pattern memory: word = address[15:0] ^ 0x5A5A
  assign mdinb = !moeb ? (maddrb[15:0] ^ 16'h5A5A) : 16'h0000;

  // ---------------- continuous invariants on instance A ----------------
  logic mon_en = 1'b0;
  always @(negedge Clk) begin
    if (mon_en) begin
      check("oe_we_both_low", 32'(!moe && !mwe), 0);
      check("ack_overlap", 32'(ack0 && ack1), 0);
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic preload(input logic [19:0] a, input logic [15:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    step();
    pl_en   = 1'b0;
  endtask

  int we_lo, ack_n;
  int ack_cyc  [4];
  int ack_port [4];
  int b_cyc    [2];
  logic [15:0] b_dat [2];

  initial begin
    Reset = 1'b1;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    req0b = 0; we0b = 0; addr0b = '0; wdata0b = '0;
    req1b = 0; we1b = 0; addr1b = '0; wdata1b = '0;

    preload(20'h00123, 16'hBEEF);
    preload(20'h00200, 16'hCAFE);
    preload(20'h00300, 16'h1111);
    step();

    // ---- reset state ----
    check("rst_ce",      32'(mce), 1);
    check("rst_oe",      32'(moe), 1);
    check("rst_we",      32'(mwe), 1);
    check("rst_ub_lb",   32'({mub, mlb}), 3);
    check("rst_dout_en", 32'(mdout_en), 0);
    check("rst_addr",    32'(maddr), 0);
    check("rst_dout",    32'(mdout), 0);
    check("rst_busy",    32'(busy), 0);
    check("rst_acks",    32'({ack0, ack1}), 0);
    check("rst_rdata",   32'(rdata), 0);
    Reset = 1'b0;
    mon_en = 1'b1;
    step();

    // ---- test 1: port 0 read of 0x00123 ----
    req0 = 1; we0 = 0; addr0 = 20'h00123;
    step();  // cycle 1: SETUP
    check("t1_c1_busy", 32'(busy), 1);
    check("t1_c1_ce",   32'(mce), 0);
    check("t1_c1_oe",   32'(moe), 1);
    check("t1_c1_addr", 32'(maddr), 'h00123);
    check("t1_c1_den",  32'(mdout_en), 0);
    step();  // cycle 2
    check("t1_c2_oe",   32'(moe), 0);
    step();  // cycle 3
    check("t1_c3_oe",   32'(moe), 0);
    check("t1_c3_ack",  32'(ack0), 0);
    step();  // cycle 4: DONE
    check("t1_c4_ack0",  32'(ack0), 1);
    check("t1_c4_rdata", 32'(rdata), 'hBEEF);
    check("t1_c4_oe",    32'(moe), 1);
    check("t1_c4_ce",    32'(mce), 0);
    req0 = 0;
    step();  // cycle 5: IDLE
    check("t1_c5_busy", 32'(busy), 0);
    check("t1_c5_ack0", 32'(ack0), 0);
    check("t1_c5_ce",   32'(mce), 1);

    // ---- test 2: port 1 write 0x1234 -> 0x0FFFF ----
    req1 = 1; we1 = 1; addr1 = 20'h0FFFF; wdata1 = 16'h1234;
    step();  // cycle 1
    check("t2_c1_den",  32'(mdout_en), 1);
    check("t2_c1_dout", 32'(mdout), 'h1234);
    check("t2_c1_we",   32'(mwe), 1);
    check("t2_c1_addr", 32'(maddr), 'h0FFFF);
    we_lo = 0;
    ack_n = 0;
    for (int c = 2; c <= 4; c++) begin
      step();
      if (!mwe) we_lo++;
      if (ack1) ack_n++;
      check("t2_den_held", 32'(mdout_en), 1);
    end
    check("t2_c4_ack1",  32'(ack1), 1);
    check("t2_c4_rdata", 32'(rdata), 'hBEEF);
    req1 = 0;
    step();  // cycle 5
    if (ack1) ack_n++;
    check("t2_we_low_cycles", 32'(we_lo), 2);
    check("t2_ack1_pulses",   32'(ack_n), 1);
    check("t2_c5_den",  32'(mdout_en), 0);
    check("t2_c5_busy", 32'(busy), 0);
    check("t2_mem",     32'(mem_a[20'h0FFFF]), 'h1234);

    // ---- test 3: simultaneous continuous requests after reset ----
    Reset = 1'b1;
    step();
    check("t3_rst_rdata", 32'(rdata), 0);
    Reset = 1'b0;
    step();  // cycle 0
    req0 = 1; we0 = 0; addr0 = 20'h00123;
    req1 = 1; we1 = 0; addr1 = 20'h00200;
    ack_n = 0;
    for (int c = 1; c <= 19; c++) begin
      step();
      if (ack0 || ack1) begin
        if (ack_n < 4) begin
          ack_cyc[ack_n]  = c;
          ack_port[ack_n] = ack1 ? 1 : 0;
        end
        ack_n++;
      end
    end
    req0 = 0; req1 = 0;
    check("t3_ack_count", 32'(ack_n), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < ack_n) begin
        check("t3_ack_cycle", 32'(ack_cyc[i]), 32'(4 + 5 * i));
        check("t3_ack_port",  32'(ack_port[i]), 32'(i % 2));
      end
    end
    step();  // cycle 20
    check("t3_idle_after", 32'(busy), 0);
    step();
    check("t3_no_regrant", 32'(busy), 0);

    // ---- test 4: req0 dropped and addr0 changed mid-access ----
    req0 = 1; we0 = 0; addr0 = 20'h00200;
    step();  // cycle 1
    step();  // cycle 2
    req0 = 0; addr0 = 20'h00300;
    step();  // cycle 3
    check("t4_addr_held", 32'(maddr), 'h00200);
    step();  // cycle 4
    check("t4_ack0",  32'(ack0), 1);
    check("t4_rdata", 32'(rdata), 'hCAFE);
    step();
    check("t4_busy", 32'(busy), 0);

    // ---- test 5: reset in second ACCESS cycle of a write ----
    req0 = 1; we0 = 1; addr0 = 20'h00040; wdata0 = 16'h7777;
    step();  // cycle 1
    step();  // cycle 2
    step();  // cycle 3: second ACCESS cycle
    check("t5_c3_we", 32'(mwe), 0);
    Reset = 1'b1;
    req0 = 0;
    step();  // cycle 4
    check("t5_we",    32'(mwe), 1);
    check("t5_oe",    32'(moe), 1);
    check("t5_ce",    32'(mce), 1);
    check("t5_den",   32'(mdout_en), 0);
    check("t5_busy",  32'(busy), 0);
    check("t5_ack",   32'({ack0, ack1}), 0);
    check("t5_rdata", 32'(rdata), 0);
    Reset = 1'b0;
    ack_n = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (ack0 || ack1) ack_n++;
    end
    check("t5_no_ack_after", 32'(ack_n), 0);

    // ---- test 6: ACCESS_CYCLES=1, back-to-back reads of 0x0 then 0x1 ----
    req0b = 1; we0b = 0; addr0b = 20'h00000;
    ack_n = 0;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (ack0b) begin
        if (ack_n < 2) begin
          b_cyc[ack_n] = c;
          b_dat[ack_n] = rdatab;
        end
        ack_n++;
        addr0b = 20'h00001;
      end
      if (c == 7) req0b = 0;
    end
    check("t6_ack_count", 32'(ack_n), 2);
    if (ack_n >= 1) begin
      check("t6_ack0_cycle", 32'(b_cyc[0]), 3);
      check("t6_ack0_data",  32'(b_dat[0]), 'h5A5A);
    end
    if (ack_n >= 2) begin
      check("t6_ack1_cycle", 32'(b_cyc[1]), 7);
      check("t6_ack1_data",  32'(b_dat[1]), 'h5A5B);
    end
    step();
    check("t6_idle", 32'(busyb), 0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
